// File: rtl/tqvp_stevej_wdt_escalator.sv
// Watchdog escalation controller: warning IRQ, programmable grace period, then a timed
// system-reset pulse. TinyQV peripheral bus slave with CTRL/GRACE/STATUS/CLEAR registers.
module tqvp_stevej_wdt_escalator #(
   parameter int         GRACE_W   = 16,
   parameter int         RST_PULSE = 16,
   parameter logic [7:0] CLR_KEY   = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   input  logic        wdt_expired,
   input  logic        wdt_pat,
   output logic        warn_irq,
   output logic        sys_reset_n
);
   localparam int PW    = $clog2(RST_PULSE + 1);
   localparam int CNT_W = (GRACE_W > PW) ? GRACE_W : PW;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_WARN  = 2'd2,
      S_RESET = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               arm_q, arm_d;
   logic               lock_q, lock_d;
   logic [GRACE_W-1:0] grace_q, grace_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         rst_cnt_q, rst_cnt_d;
   logic               warn_q, warn_d;
   logic               srn_q, srn_d;

   logic wr, ctrl_wr, grace_wr, disarm, clear_ok;

   // Reads are side-effect free, so data_read_n is not needed.
   logic unused_in;
   assign unused_in = ^{data_read_n, data_in};

   assign wr       = (data_write_n != 2'b11);
   assign ctrl_wr  = wr && (address == 6'h00);
   assign grace_wr = wr && (address == 6'h01) && !lock_q;
   assign disarm   = ctrl_wr && !lock_q && !data_in[0];
   assign clear_ok = wr && (address == 6'h03) && (data_in[7:0] == CLR_KEY);

   always_comb begin
      state_d   = state_q;
      arm_d     = arm_q;
      lock_d    = lock_q;
      grace_d   = grace_q;
      cnt_d     = cnt_q;
      rst_cnt_d = rst_cnt_q;
      warn_d    = warn_q;
      srn_d     = srn_q;

      if (ctrl_wr) begin
         if (!lock_q) arm_d = data_in[0];
         lock_d = lock_q | data_in[1];
      end
      if (grace_wr) grace_d = data_in[GRACE_W-1:0];

      case (state_q)
         S_IDLE: begin
            if (arm_q && !disarm) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (disarm) begin
               state_d = S_IDLE;
            end else if (wdt_expired) begin
               state_d = S_WARN;
               cnt_d   = CNT_W'(grace_q);
               warn_d  = 1'b1;
            end
         end
         S_WARN: begin
            // Disarm beats recovery, which beats grace expiry.
            if (disarm) begin
               state_d = S_IDLE;
               warn_d  = 1'b0;
            end else if (clear_ok || wdt_pat) begin
               state_d = S_ARMED;
               warn_d  = 1'b0;
            end else if (cnt_q == '0) begin
               state_d = S_RESET;
               warn_d  = 1'b0;
               srn_d   = 1'b0;
               cnt_d   = CNT_W'(RST_PULSE - 1);
               if (rst_cnt_q != 8'hFF) rst_cnt_d = rst_cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            if (cnt_q == '0) begin
               srn_d = 1'b1;
               if (lock_q) begin
                  state_d = S_ARMED;
               end else begin
                  state_d = S_IDLE;
                  arm_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         arm_q     <= 1'b0;
         lock_q    <= 1'b0;
         grace_q   <= '1;
         cnt_q     <= '0;
         rst_cnt_q <= 8'd0;
         warn_q    <= 1'b0;
         srn_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         arm_q     <= arm_d;
         lock_q    <= lock_d;
         grace_q   <= grace_d;
         cnt_q     <= cnt_d;
         rst_cnt_q <= rst_cnt_d;
         warn_q    <= warn_d;
         srn_q     <= srn_d;
      end
   end

   always_comb begin
      case (address)
         6'h00:   data_out = {30'd0, lock_q, arm_q};
         6'h01:   data_out = 32'(grace_q);
         6'h02:   data_out = {16'd0, rst_cnt_q, 6'd0, state_q};
         default: data_out = 32'd0;
      endcase
   end

   assign data_ready  = 1'b1;
   assign warn_irq    = warn_q;
   assign sys_reset_n = srn_q;

endmodule

// File: tb/tb_tqvp_stevej_wdt_escalator.sv
// Bench for the watchdog escalator: directed scenarios plus randomized traffic checked
// against a cycle-count model of the escalation rules.
module tb_tqvp_stevej_wdt_escalator;
   localparam int IDLE = 0, ARMED = 1, WARN = 2, RESET = 3;
   localparam int PULSE = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  address = '0;
   logic [31:0] data_in = '0;
   logic [1:0]  data_write_n = 2'b11;
   logic [1:0]  data_read_n = 2'b11;
   logic [31:0] data_out;
   logic        data_ready;
   logic        wdt_expired = 1'b0;
   logic        wdt_pat = 1'b0;
   logic        warn_irq;
   logic        sys_reset_n;

   int checks = 0;
   int errors = 0;

   // model state: remaining WARN / pulse cycles instead of a shared down-counter
   int m_st, m_arm, m_lock, m_grace, m_warn_left, m_pulse_left, m_rstcnt, m_warn, m_srn;

   tqvp_stevej_wdt_escalator dut (
      .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
      .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
      .data_ready(data_ready), .wdt_expired(wdt_expired), .wdt_pat(wdt_pat),
      .warn_irq(warn_irq), .sys_reset_n(sys_reset_n)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [5:0] a, input logic [31:0] d);
      address = a;
      data_in = d;
      data_write_n = 2'b00;
      step();
      data_write_n = 2'b11;
      data_in = '0;
   endtask

   task automatic model_reset();
      m_st = IDLE; m_arm = 0; m_lock = 0; m_grace = 16'hFFFF;
      m_warn_left = 0; m_pulse_left = 0; m_rstcnt = 0; m_warn = 0; m_srn = 1;
   endtask

   task automatic do_reset();
      data_write_n = 2'b11; wdt_expired = 0; wdt_pat = 0; address = '0; data_in = '0;
      #2 rst_n = 1'b0;
      #7 rst_n = 1'b1;
      model_reset();
      step();
   endtask

   function automatic logic [31:0] model_read(input logic [5:0] a);
      case (a)
         6'h00:   return 32'(m_lock * 2 + m_arm);
         6'h01:   return 32'(m_grace);
         6'h02:   return 32'(m_rstcnt * 256 + m_st);
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge(input logic w, input logic [5:0] a, input logic [31:0] d,
                             input logic e, input logic p);
      int n_st, n_arm, n_lock, n_grace;
      bit dis, clr;
      n_st = m_st; n_arm = m_arm; n_lock = m_lock; n_grace = m_grace;
      dis = w && a == 0 && m_lock == 0 && d[0] == 0;
      clr = w && a == 3 && d[7:0] == 8'hA5;
      if (w && a == 0) begin
         if (m_lock == 0) n_arm = int'(d[0]);
         if (d[1]) n_lock = 1;
      end
      if (w && a == 1 && m_lock == 0) n_grace = int'(d[15:0]);
      if (m_st == IDLE) begin
         if (m_arm == 1 && !dis) n_st = ARMED;
      end else if (m_st == ARMED) begin
         if (dis) n_st = IDLE;
         else if (e) begin n_st = WARN; m_warn_left = m_grace + 1; m_warn = 1; end
      end else if (m_st == WARN) begin
         if (dis) begin n_st = IDLE; m_warn = 0; end
         else if (clr || p) begin n_st = ARMED; m_warn = 0; end
         else if (m_warn_left == 1) begin
            n_st = RESET; m_warn = 0; m_srn = 0; m_pulse_left = PULSE;
            if (m_rstcnt < 255) m_rstcnt++;
         end else m_warn_left--;
      end else begin
         if (m_pulse_left == 1) begin
            m_srn = 1;
            if (m_lock == 1) n_st = ARMED;
            else begin n_st = IDLE; n_arm = 0; end
         end else m_pulse_left--;
      end
      m_st = n_st; m_arm = n_arm; m_lock = n_lock; m_grace = n_grace;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (warn_irq !== 1'b0) begin errors++; $display("FAIL rst_warn got %b want 0", warn_irq); end
      checks++; if (sys_reset_n !== 1'b1) begin errors++; $display("FAIL rst_srn got %b want 1", sys_reset_n); end
      checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", data_ready); end
      address = 6'h02; #1;
      checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL rst_status got %h want 0", data_out); end
      address = 6'h01; #1;
      checks++; if (data_out !== 32'h0000FFFF) begin errors++; $display("FAIL rst_grace got %h want 0000ffff", data_out); end
      address = 6'h00; #1;
      checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL rst_ctrl got %h want 0", data_out); end
   endtask

   task automatic test_escalation();
      int wc, rc;
      do_reset();
      wr_reg(6'h01, 32'd3);
      wr_reg(6'h00, 32'd1);
      step();
      address = 6'h02; #1;
      checks++; if (data_out !== 32'd1) begin errors++; $display("FAIL esc_armed got %h want 1", data_out); end
      wdt_expired = 1; step(); wdt_expired = 0;
      wc = 0; rc = 0;
      for (int i = 0; i < 40; i++) begin
         if (warn_irq) wc++;
         if (!sys_reset_n) rc++;
         step();
      end
      checks++; if (wc !== 4) begin errors++; $display("FAIL esc_warn_len got %0d want 4", wc); end
      checks++; if (rc !== PULSE) begin errors++; $display("FAIL esc_pulse_len got %0d want %0d", rc, PULSE); end
      #1;
      checks++; if (data_out !== 32'h100) begin errors++; $display("FAIL esc_status got %h want 100", data_out); end
      address = 6'h00; #1;
      checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL esc_ctrl got %h want 0", data_out); end
   endtask

   task automatic test_clear();
      int lowc, rc;
      do_reset();
      wr_reg(6'h01, 32'd10);
      wr_reg(6'h00, 32'd1);
      step();
      wdt_expired = 1; step(); wdt_expired = 0;
      step();
      wr_reg(6'h03, 32'hA5);
      checks++; if (warn_irq !== 1'b0) begin errors++; $display("FAIL clr_warn got %b want 0", warn_irq); end
      address = 6'h02; #1;
      checks++; if (data_out !== 32'd1) begin errors++; $display("FAIL clr_state got %h want 1", data_out); end
      lowc = 0;
      for (int i = 0; i < 20; i++) begin
         if (!sys_reset_n) lowc++;
         step();
      end
      checks++; if (lowc !== 0) begin errors++; $display("FAIL clr_no_pulse got %0d low cycles want 0", lowc); end
      wdt_expired = 1; step(); wdt_expired = 0;
      step();
      wr_reg(6'h03, 32'h5A);
      checks++; if (warn_irq !== 1'b1) begin errors++; $display("FAIL badkey_warn got %b want 1", warn_irq); end
      rc = 0;
      for (int i = 0; i < 40; i++) begin
         if (!sys_reset_n) rc++;
         step();
      end
      checks++; if (rc !== PULSE) begin errors++; $display("FAIL badkey_pulse got %0d want %0d", rc, PULSE); end
      address = 6'h02; #1;
      checks++; if (data_out !== 32'h100) begin errors++; $display("FAIL badkey_status got %h want 100", data_out); end
   endtask

   task automatic test_lock();
      int rc;
      do_reset();
      wr_reg(6'h01, 32'd5);
      wr_reg(6'h00, 32'd3);
      wr_reg(6'h01, 32'd100);
      wr_reg(6'h00, 32'd0);
      address = 6'h01; #1;
      checks++; if (data_out !== 32'd5) begin errors++; $display("FAIL lock_grace got %0d want 5", data_out); end
      address = 6'h00; #1;
      checks++; if (data_out !== 32'd3) begin errors++; $display("FAIL lock_ctrl got %h want 3", data_out); end
      address = 6'h02; #1;
      checks++; if (data_out !== 32'd1) begin errors++; $display("FAIL lock_armed got %h want 1", data_out); end
      wdt_expired = 1; step(); wdt_expired = 0;
      rc = 0;
      for (int i = 0; i < 40; i++) begin
         if (!sys_reset_n) rc++;
         step();
      end
      checks++; if (rc !== PULSE) begin errors++; $display("FAIL lock_pulse got %0d want %0d", rc, PULSE); end
      #1;
      checks++; if (data_out !== 32'h101) begin errors++; $display("FAIL lock_after got %h want 101", data_out); end
   endtask

   task automatic test_grace0();
      do_reset();
      wr_reg(6'h01, 32'd0);
      wr_reg(6'h00, 32'd1);
      step();
      wdt_expired = 1; step(); wdt_expired = 0;
      checks++; if (warn_irq !== 1'b1) begin errors++; $display("FAIL g0_warn got %b want 1", warn_irq); end
      wdt_pat = 1; step(); wdt_pat = 0;
      address = 6'h02; #1;
      checks++; if (data_out !== 32'd1 || sys_reset_n !== 1'b1)
         begin errors++; $display("FAIL g0_pat got status %h srn %b want 1/1", data_out, sys_reset_n); end
      wdt_expired = 1; step(); wdt_expired = 0;
      step();
      checks++; if (data_out !== 32'h103 || sys_reset_n !== 1'b0)
         begin errors++; $display("FAIL g0_nopat got status %h srn %b want 103/0", data_out, sys_reset_n); end
   endtask

   task automatic test_async_reset();
      do_reset();
      wr_reg(6'h01, 32'd1);
      wr_reg(6'h00, 32'd3);
      step();
      wdt_expired = 1; step(); wdt_expired = 0;
      step(); step(); step(); step();
      checks++; if (sys_reset_n !== 1'b0) begin errors++; $display("FAIL ar_in_pulse got %b want 0", sys_reset_n); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (sys_reset_n !== 1'b1 || warn_irq !== 1'b0)
         begin errors++; $display("FAIL ar_outs got srn %b warn %b want 1/0", sys_reset_n, warn_irq); end
      address = 6'h02; #1;
      checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL ar_status got %h want 0", data_out); end
      address = 6'h01; #1;
      checks++; if (data_out !== 32'h0000FFFF) begin errors++; $display("FAIL ar_grace got %h want ffff", data_out); end
      address = 6'h00; #1;
      checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL ar_ctrl got %h want 0", data_out); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_random();
      logic w, e, p;
      logic [5:0] a;
      logic [31:0] d;
      int sel;
      for (int ep = 0; ep < 4; ep++) begin
         do_reset();
         for (int i = 0; i < 500; i++) begin
            w = ($urandom_range(0, 9) < 3);
            sel = $urandom_range(0, 4);
            a = (sel == 4) ? 6'($urandom_range(4, 63)) : 6'(sel);
            d = $urandom;
            if (a == 6'h00) d = {30'd0, ($urandom_range(0, 99) < 3), ($urandom_range(0, 3) != 0)};
            if (a == 6'h01) d = 32'($urandom_range(0, 6));
            if (a == 6'h03 && $urandom_range(0, 1) == 1) d[7:0] = 8'hA5;
            e = ($urandom_range(0, 9) < 2);
            p = ($urandom_range(0, 9) == 0);
            address = a; data_in = d; data_write_n = w ? 2'($urandom_range(0, 2)) : 2'b11;
            data_read_n = 2'($urandom_range(0, 3));
            wdt_expired = e; wdt_pat = p;
            #1;
            checks++; if (warn_irq !== (m_warn == 1))
               begin errors++; $display("FAIL rnd_warn cyc %0d got %b want %0d", i, warn_irq, m_warn); end
            checks++; if (sys_reset_n !== (m_srn == 1))
               begin errors++; $display("FAIL rnd_srn cyc %0d got %b want %0d", i, sys_reset_n, m_srn); end
            checks++; if (data_out !== model_read(a))
               begin errors++; $display("FAIL rnd_read cyc %0d addr %h got %h want %h", i, a, data_out, model_read(a)); end
            model_edge(w, a, d, e, p);
            step();
         end
      end
      data_write_n = 2'b11; wdt_expired = 0; wdt_pat = 0;
   endtask

   initial begin
      test_reset();
      test_escalation();
      test_clear();
      test_lock();
      test_grace0();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
